// File: rtl/unpack_pkg.sv
// Shared constants and encodings for the word-to-byte unpacker.
package unpack_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_W_DEF = 32;
   localparam int unsigned NBYTES     = WORD_W_DEF / BYTE_W;
   localparam int unsigned LEN_W      = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam logic ORDER_MSB = 1'b0;
   localparam logic ORDER_LSB = 1'b1;

endpackage

// File: rtl/byte_lane_sel.sv
// Combinational byte lane picker: returns byte k of a word, counted from
// the top (MSB-first) or the bottom (LSB-first) of the word.
module byte_lane_sel #(
   parameter int unsigned WORD_W = unpack_pkg::WORD_W_DEF,
   parameter int unsigned BYTE_W = unpack_pkg::BYTE_W,
   parameter int unsigned K_W    = unpack_pkg::LEN_W
) (
   input  logic [WORD_W-1:0] i_word,
   input  logic [K_W-1:0]    i_k,
   input  logic              i_order,
   output logic [BYTE_W-1:0] o_byte
);
   import unpack_pkg::*;

   logic [31:0] w_off;

   // Full 32-bit offset so k*8 never wraps.
   assign w_off = 32'(i_k) * BYTE_W;

   always_comb begin
      o_byte = '0;
      if (w_off + BYTE_W <= WORD_W) begin
         if (i_order == ORDER_LSB) begin
            o_byte = BYTE_W'(i_word >> w_off);
         end else begin
            o_byte = BYTE_W'(i_word >> (WORD_W - BYTE_W - w_off));
         end
      end
   end

endmodule

// File: rtl/word_unpacker.sv
// Accepts a word with a byte count and order, then streams its bytes out
// one per transfer under valid/ready, chaining words with no bubble.
module word_unpacker #(
   parameter int unsigned WORD_W = unpack_pkg::WORD_W_DEF,
   parameter int unsigned BYTE_W = unpack_pkg::BYTE_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic [1:0]        len_i,
   input  logic              order_i,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   output logic [BYTE_W-1:0] byte_o,
   output logic              byte_valid_o,
   input  logic              byte_ready_i,
   output logic              byte_last_o,
   output logic              busy_o
);
   import unpack_pkg::*;

   localparam int unsigned K_W = LEN_W;

   state_t            r_state, w_state_nxt;
   logic [WORD_W-1:0] r_word, w_word_nxt;
   logic [K_W-1:0]    r_len, w_len_nxt;
   logic [K_W-1:0]    r_k, w_k_nxt;
   logic              r_order, w_order_nxt;
   logic [BYTE_W-1:0] r_byte, w_sel_byte;
   logic              r_last;
   logic              w_xfer, w_ready, w_accept;

   assign w_xfer   = (r_state == ST_EMIT) && byte_ready_i;
   assign w_ready  = (r_state == ST_IDLE) || (w_xfer && r_last);
   assign w_accept = word_valid_i && w_ready;

   // Next-state: a new word wins over advancing, which covers the
   // last-byte handoff as well as the idle case.
   always_comb begin
      w_state_nxt = r_state;
      w_word_nxt  = r_word;
      w_len_nxt   = r_len;
      w_order_nxt = r_order;
      w_k_nxt     = r_k;
      if (w_accept) begin
         w_state_nxt = ST_EMIT;
         w_word_nxt  = word_i;
         w_len_nxt   = len_i;
         w_order_nxt = order_i;
         w_k_nxt     = '0;
      end else if (w_xfer) begin
         if (r_last) begin
            w_state_nxt = ST_IDLE;
            w_k_nxt     = '0;
         end else begin
            w_k_nxt = r_k + K_W'(1);
         end
      end
   end

   // Lane select runs on next-state values so byte_o comes from a flop.
   byte_lane_sel #(
      .WORD_W (WORD_W),
      .BYTE_W (BYTE_W),
      .K_W    (K_W)
   ) u_lane_sel (
      .i_word  (w_word_nxt),
      .i_k     (w_k_nxt),
      .i_order (w_order_nxt),
      .o_byte  (w_sel_byte)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_word  <= '0;
         r_len   <= '0;
         r_order <= ORDER_MSB;
         r_k     <= '0;
         r_byte  <= '0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_word  <= w_word_nxt;
         r_len   <= w_len_nxt;
         r_order <= w_order_nxt;
         r_k     <= w_k_nxt;
         r_byte  <= (w_state_nxt == ST_EMIT) ? w_sel_byte : '0;
         r_last  <= (w_state_nxt == ST_EMIT) && (w_k_nxt == w_len_nxt);
      end
   end

   assign word_ready_o = w_ready;
   assign byte_o       = r_byte;
   assign byte_valid_o = (r_state == ST_EMIT);
   assign byte_last_o  = r_last;
   assign busy_o       = (r_state == ST_EMIT);

endmodule

// File: tb/tb_word_unpacker.sv
// Scoreboard bench for word_unpacker: directed scenarios plus random words,
// expected bytes built from a byte-list model of each accepted word.
module tb_word_unpacker;
   import unpack_pkg::*;

   localparam int unsigned WW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [WW-1:0] word_i = '0;
   logic [1:0]    len_i = '0;
   logic          order_i = 1'b0;
   logic          word_valid_i = 1'b0;
   logic          word_ready_o;
   logic [7:0]    byte_o;
   logic          byte_valid_o;
   logic          byte_ready_i;
   logic          byte_last_o;
   logic          busy_o;

   word_unpacker #(.WORD_W(WW), .BYTE_W(8)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .word_i       (word_i),
      .len_i        (len_i),
      .order_i      (order_i),
      .word_valid_i (word_valid_i),
      .word_ready_o (word_ready_o),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .byte_ready_i (byte_ready_i),
      .byte_last_o  (byte_last_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [7:0] b;
      logic       last;
   } exp_t;

   exp_t q[$];
   int   xfer_cyc[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic rand_mode    = 1'b0;
   logic forced_ready = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: split the word into bytes, order them, keep len+1.
   task automatic push_word(input logic [WW-1:0] w, input logic [1:0] len, input logic ord);
      logic [7:0] lsb_list[$];
      logic [7:0] seq[$];
      exp_t       e;
      logic [WW-1:0] t;
      t = w;
      for (int j = 0; j < int'(WW / 8); j++) begin
         lsb_list.push_back(t[7:0]);
         t = t >> 8;
      end
      seq = (ord == ORDER_LSB) ? lsb_list : lsb_list;
      if (ord == ORDER_MSB) seq.reverse();
      for (int i = 0; i <= int'(len); i++) begin
         e.b    = seq[i];
         e.last = (i == int'(len));
         q.push_back(e);
      end
   endtask

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      #2 byte_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
   end

   // Monitor: pops the scoreboard on every transfer and checks idle/stall rules.
   exp_t       mon_e;
   logic       stall_pend = 1'b0;
   logic [7:0] stall_b;
   logic       stall_l;
   always @(negedge clk_i) begin
      if (rst_i) begin
         stall_pend = 1'b0;
      end else begin
         check("busy_eq_valid", 32'(busy_o), 32'(byte_valid_o));
         if (stall_pend) begin
            check("stall_hold_byte", 32'(byte_o), 32'(stall_b));
            check("stall_hold_last", 32'(byte_last_o), 32'(stall_l));
         end
         stall_pend = 1'b0;
         if (!byte_valid_o) begin
            check("idle_zero", {23'd0, byte_o, byte_last_o}, 32'd0);
         end else if (byte_ready_i) begin
            xfer_cyc.push_back(cyc);
            if (q.size() == 0) begin
               check("spurious_byte", 32'(byte_o), 32'h100);
            end else begin
               mon_e = q.pop_front();
               check("byte", 32'(byte_o), 32'(mon_e.b));
               check("last", 32'(byte_last_o), 32'(mon_e.last));
            end
         end else begin
            stall_pend = 1'b1;
            stall_b    = byte_o;
            stall_l    = byte_last_o;
         end
      end
   end

   // Offer a word until accepted; expected bytes are queued just before the accepting edge.
   task automatic send(input logic [WW-1:0] w, input logic [1:0] len, input logic ord);
      word_i       = w;
      len_i        = len;
      order_i      = ord;
      word_valid_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (word_ready_o) begin
            push_word(w, len, ord);
            @(posedge clk_i);
            #1 word_valid_i = 1'b0;
            return;
         end
         @(posedge clk_i);
         #1;
      end
      word_valid_i = 1'b0;
      check("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (q.size() == 0 && !byte_valid_o) begin
            @(posedge clk_i);
            #1;
            return;
         end
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_byte", 32'(byte_o), 32'd0);
      check("rst_valid", 32'(byte_valid_o), 32'd0);
      check("rst_last", 32'(byte_last_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_word_ready", 32'(word_ready_o), 32'd1);
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      // MSB-first full word, with one-cycle latency check.
      send(32'hAABBCCDD, 2'd3, ORDER_MSB);
      check("latency_valid", 32'(byte_valid_o), 32'd1);
      check("latency_byte0", 32'(byte_o), 32'hAA);
      wait_drain();

      send(32'hAABBCCDD, 2'd3, ORDER_LSB);
      wait_drain();

      send(32'h12345678, 2'd1, ORDER_MSB);
      send(32'h12345678, 2'd1, ORDER_LSB);
      wait_drain();

      // Backpressure on byte 1 with a competing word offered.
      send(32'hAABBCCDD, 2'd3, ORDER_MSB);
      @(posedge clk_i);
      #1 forced_ready = 1'b0;
      word_i       = 32'h11223344;
      len_i        = 2'd0;
      order_i      = ORDER_MSB;
      word_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("bp_byte", 32'(byte_o), 32'hBB);
         check("bp_word_ready", 32'(word_ready_o), 32'd0);
         check("bp_busy", 32'(busy_o), 32'd1);
      end
      @(posedge clk_i);
      #1 word_valid_i = 1'b0;
      forced_ready = 1'b1;
      wait_drain();

      // Back-to-back words must stream with no gap.
      xfer_cyc.delete();
      send(32'h01020304, 2'd3, ORDER_MSB);
      send(32'h05060708, 2'd3, ORDER_MSB);
      wait_drain();
      check("b2b_count", 32'(xfer_cyc.size()), 32'd8);
      if (xfer_cyc.size() == 8) check("b2b_span", 32'(xfer_cyc[7] - xfer_cyc[0]), 32'd7);

      // Random words, lengths, orders and downstream stalls.
      rand_mode = 1'b1;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk_i);
            #1;
         end
         send(WW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      wait_drain();
      rand_mode = 1'b0;
      @(posedge clk_i);
      #1;

      // Reset in the middle of a word discards the remainder.
      send(32'hAABBCCDD, 2'd3, ORDER_MSB);
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 q.delete();
      @(negedge clk_i);
      check("midrst_byte", 32'(byte_o), 32'd0);
      check("midrst_valid", 32'(byte_valid_o), 32'd0);
      check("midrst_last", 32'(byte_last_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_word_ready", 32'(word_ready_o), 32'd1);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("midrst_no_stale", 32'(byte_valid_o), 32'd0);
      end
      @(posedge clk_i);
      #1;
      send(32'h12345678, 2'd2, ORDER_MSB);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
